netwalk_port_decoder: RTL
=========================

Name: netwalk_port_decoder

Overview:
- Parametrised, buffered successor to the netwalk one-hot port decoder.
- Turns a port index into a DECODER_OUT_WIDTH-bit port mask in one of four modes, with range checking, a small output FIFO and valid/ready handshakes on both sides.
- Sits between the forwarding lookup and the per-port crossbar enables in the data plane.

Parameters:
- DECODER_IN_WIDTH, 4, width of the index input.
- DECODER_OUT_WIDTH, 1<<DECODER_IN_WIDTH, number of output ports. Legal range: 1 to 2^DECODER_IN_WIDTH.
- FIFO_DEPTH, 2, output buffer entries. Must be a power of two and at least 2.
- ERR_CNT_WIDTH, 8, width of the saturating out-of-range counter.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the FIFO contents.
- in_valid  in  1  index/mode present.
- in_ready  out  1  block can accept this cycle.
- decoder_in  in  DECODER_IN_WIDTH  port index.
- mode  in  2  00 one-hot; 01 thermometer; 10 broadcast; 11 inverted one-hot.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry.
- decoder_out  out  DECODER_OUT_WIDTH  port mask of head entry.
- out_err  out  1  head entry was out of range.
- err_count  out  ERR_CNT_WIDTH  saturating count of accepted out-of-range requests.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, pointers 0.
  - out_valid=0, decoder_out=0, out_err=0, err_count=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first edge after release.
- Accept: in_valid & in_ready at a rising edge. The encoded mask and err bit are computed combinationally and written into the FIFO at that edge.
- Mode encoding for idx = decoder_in, N = DECODER_OUT_WIDTH:
  - 00: bit idx set, all others 0.
  - 01: bits [idx:0] set.
  - 10: all N bits set. idx is ignored, so there is never a range error.
  - 11: all bits set except bit idx.
- Range check: for modes 00/01/11, idx >= N gives a mask of all zeros and err=1.
- err_count increments by 1 on each accepted err=1 entry and saturates at all-ones. It is unaffected by flush and cleared only by reset.
- Latency: exactly one cycle. An entry accepted at edge k is visible on decoder_out/out_err with out_valid=1 immediately after edge k, provided the FIFO was empty.
- Pop: out_valid & out_ready at an edge removes the head.
- Empty FIFO: out_valid=0, and decoder_out and out_err are forced to 0.
- in_ready = !full.
  - Registered-status behaviour: no combinational path from out_ready to in_ready.
  - When full, a same-cycle pop does not permit a push.
  - When not full, push and pop in the same cycle are both performed and occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- flush=1 at an edge:
  - Occupancy goes to 0 and out_valid=0 after the edge.
  - Any simultaneous push or pop is discarded; a discarded push does not increment err_count.
  - in_ready=1 after the edge.
- Mid-operation reset: all state clears immediately and asynchronously. No partial entries survive.
- Output entries are stable while out_valid=1 and out_ready=0.

Test Plan:
1. Defaults, mode 00, out_ready=1: send idx 0, 1, 7 on consecutive cycles → decoder_out 16'h0001, 16'h0002, 16'h0080, each one cycle after acceptance; out_err=0.
2. Modes with idx=4'd5: mode 01 → 16'h003F; mode 10 → 16'hFFFF; mode 11 → 16'hFFDF.
3. DECODER_OUT_WIDTH=10, mode 00:
   - idx=12 → decoder_out=10'h000, out_err=1, err_count=1.
   - Send 300 further idx=12 requests → err_count saturates at 8'hFF.
   - Mode 10 with idx=12 → 10'h3FF, out_err=0.
4. Backpressure, out_ready=0: push idx 2, 3 → in_ready=0 after the 2nd accept; a 3rd in_valid is not accepted; head holds 16'h0004. Raise out_ready → outputs in order 16'h0004, then 16'h0008; in_ready returns to 1.
5. Simultaneous push/pop with occupancy 1 → occupancy stays 1 and order is preserved. With FIFO full, pop plus in_valid → only the pop occurs.
6. Two entries queued, then:
   - flush → out_valid=0 next cycle, err_count unchanged.
   - Drive reset=0 asynchronously mid-stream → out_valid, decoder_out and err_count read 0 before the next clk edge.

Source files
------------

// File: rtl/netwalk_port_decoder.sv
// netwalk_port_decoder: port index to port mask encoder (four modes, range check) feeding a small valid/ready output FIFO
module netwalk_port_decoder #(
    parameter int DECODER_IN_WIDTH  = 4,
    parameter int DECODER_OUT_WIDTH = 1 << DECODER_IN_WIDTH,
    parameter int FIFO_DEPTH        = 2,
    parameter int ERR_CNT_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DECODER_IN_WIDTH-1:0]  decoder_in,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DECODER_OUT_WIDTH-1:0] decoder_out,
    output logic                         out_err,
    output logic [ERR_CNT_WIDTH-1:0]     err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DECODER_OUT_WIDTH-1:0] one_hot, thermo, enc_mask;
    logic                         enc_err;
    logic [DECODER_OUT_WIDTH-1:0] mask_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]        err_mem;
    logic [AW:0]                  wr_ptr, rd_ptr;
    logic                         ready_en, full, empty, push, pop;
    always_comb begin
        one_hot = '0;
        thermo  = '0;
        for (int i = 0; i < DECODER_OUT_WIDTH; i++) begin
            one_hot[i] = 32'(decoder_in) == 32'(i);
            thermo[i]  = 32'(i) <= 32'(decoder_in);
        end
        enc_err  = mode != 2'b10 && 32'(decoder_in) >= 32'(DECODER_OUT_WIDTH);
        enc_mask = enc_err ? '0 : mode == 2'b00 ? one_hot : mode == 2'b01 ? thermo :
                   mode == 2'b10 ? '1 : ~one_hot;
    end
    // extra pointer bit separates full from empty; in_ready only sees registered state
    assign full        = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign empty       = wr_ptr == rd_ptr;
    assign in_ready    = ready_en && !full;
    assign out_valid   = !empty;
    assign push        = in_valid && in_ready && !flush;
    assign pop         = out_valid && out_ready && !flush;
    assign decoder_out = empty ? '0 : mask_mem[rd_ptr[AW-1:0]];
    assign out_err     = !empty && err_mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ready_en  <= 1'b0;
            err_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
                if (push && enc_err && err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr[AW-1:0]] <= enc_mask;
            err_mem[wr_ptr[AW-1:0]]  <= enc_err;
        end
    end
endmodule
